// File: rtl/jesd204_clk_pkg.sv
// jesd204_clk_pkg: state encoding and shared widths for the JESD204 clock/reset sequencer
package jesd204_clk_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } seq_state_t;
    localparam int DEGLITCH_LEN = 4;
    localparam int RETRY_W = 8;
endpackage

// File: rtl/jesd204_clk_rst_seq_if.sv
// jesd204_clk_rst_seq_if: board control, clock-manager and link-reset signals of the sequencer
interface jesd204_clk_rst_seq_if;
    import jesd204_clk_pkg::*;
    logic enable;
    logic fault_clr;
    logic mgr_locked;
    logic mgr_reset;
    logic link_reset;
    logic ready;
    logic fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0] state;
    modport master (
        output enable, fault_clr, mgr_locked,
        input  mgr_reset, link_reset, ready, fault, retry_cnt, state
    );
    modport slave (
        input  enable, fault_clr, mgr_locked,
        output mgr_reset, link_reset, ready, fault, retry_cnt, state
    );
endinterface

// File: rtl/jesd204_sync_2ff.sv
// jesd204_sync_2ff: parameterised-width two-flop synchronizer with async active-high reset
module jesd204_sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk_in or posedge reset)
        if (reset) {q, meta} <= '0;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/jesd204_clk_rst_seq.sv
// jesd204_clk_rst_seq: clock-manager reset/lock sequencer gating the link reset on clock health.
// Define JESD204_LOCK_DEGLITCH_EN to require DEGLITCH_LEN low cycles of lock before leaving RUN.
module jesd204_clk_rst_seq
    import jesd204_clk_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input logic clk_in,
    input logic reset,
    jesd204_clk_rst_seq_if.slave bus
);
    seq_state_t state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic lock_s, lock_lost, fail;
    logic mgr_reset_q, link_reset_q, ready_q, fault_q;

    jesd204_sync_2ff #(.W(1)) u_sync (.clk_in, .reset, .d(bus.mgr_locked), .q(lock_s));

`ifdef JESD204_LOCK_DEGLITCH_EN
    localparam int GW = $clog2(DEGLITCH_LEN);
    logic [GW-1:0] glitch_q;
    always_ff @(posedge clk_in or posedge reset)
        if (reset) glitch_q <= '0;
        else glitch_q <= (state_q == RUN && !lock_s) ? glitch_q + GW'(1) : '0;
    assign lock_lost = !lock_s && glitch_q == GW'(DEGLITCH_LEN - 1);
`else
    assign lock_lost = !lock_s;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        fail    = 1'b0;
        if (!bus.enable && state_q != FAULT) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:      state_d = PLL_RST;
                PLL_RST:   if (timer_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
                           else timer_d = timer_q + CNT_W'(1);
                WAIT_LOCK: if (lock_s) state_d = SETTLE;
                           else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1)) fail = 1'b1;
                           else timer_d = timer_q + CNT_W'(1);
                SETTLE:    if (lock_s && timer_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = RUN;
                           else if (lock_s) timer_d = timer_q + CNT_W'(1);
                RUN:       fail = lock_lost;
                FAULT:     if (bus.fault_clr) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
        // the retry budget is judged on the count before this failure is added
        if (fail) state_d = (int'(retry_q) < MAX_RETRIES) ? PLL_RST : FAULT;
        retry_d = (state_d == IDLE) ? '0 : (fail && retry_q != '1) ? retry_q + RETRY_W'(1) : retry_q;
    end

    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            retry_q      <= '0;
            mgr_reset_q  <= 1'b1;
            link_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            mgr_reset_q  <= state_d == IDLE || state_d == PLL_RST || state_d == FAULT;
            link_reset_q <= state_d != RUN;
            ready_q      <= state_d == RUN;
            fault_q      <= state_d == FAULT;
        end

    assign bus.mgr_reset  = mgr_reset_q;
    assign bus.link_reset = link_reset_q;
    assign bus.ready      = ready_q;
    assign bus.fault      = fault_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.state      = state_q;
endmodule

// File: doc/jesd204_clk_rst_seq.md
Name: jesd204_clk_rst_seq

Overview:
- Sequencer that owns the reset of the JESD204 clock manager and gates the link-layer reset on clock health.
- Pulses the manager reset, waits for lock with a timeout, enforces a settle window, then releases the link reset.
- Detects loss of lock and re-runs the sequence, with a bounded number of retries.
- Sits between the board-level reset/enable and the clock manager plus TX/RX link cores.

Parameters:
- RST_CYCLES, 16: width of the mgr_reset pulse in clk_in cycles (min 1).
- LOCK_TIMEOUT, 4096: clk_in cycles to wait for lock before counting a failed attempt.
- SETTLE_CYCLES, 256: cycles lock must be held continuously before link_reset is released (min 1).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (0 means the first failure is fatal).
- CNT_W, 16: timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES).

Ports:
- clk_in  in  1  free-running reference clock; the block's only clock.
- reset  in  1  asynchronous, active-high block reset.
- enable  in  1  level; 1 requests the link up, 0 forces a return to IDLE.
- fault_clr  in  1  single-cycle pulse; leaves FAULT.
- mgr_locked  in  1  lock from clock manager, asynchronous to clk_in.
- mgr_reset  out  1  reset to clock manager, active-high.
- link_reset  out  1  reset to link cores, active-high.
- ready  out  1  1 only in RUN.
- fault  out  1  1 only in FAULT.
- retry_cnt  out  8  failed attempts since the last IDLE exit; saturates at 255.
- state  out  3  encoded FSM state for debug/CSR.

Behaviour:
- Reset values:
  - mgr_reset=1, link_reset=1, ready=0, fault=0, retry_cnt=0.
  - state=IDLE, timer=0, lock synchronizer=0.
- mgr_locked passes through a 2-flop synchronizer (lock_s); all decisions use lock_s, so there is 2 cycles of input latency.
- State encoding: IDLE=0, PLL_RST=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5.
- IDLE:
  - Outputs: mgr_reset=1, link_reset=1, retry_cnt cleared.
  - enable=1 -> PLL_RST with timer=0.
- PLL_RST:
  - mgr_reset=1 for exactly RST_CYCLES cycles.
  - Then -> WAIT_LOCK with timer=0 and mgr_reset=0 in the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - lock_s=1 -> SETTLE with timer=0.
  - timer reaching LOCK_TIMEOUT-1 with lock_s=0 is a failed attempt:
    - retry_cnt increments.
    - If the pre-increment count is < MAX_RETRIES -> PLL_RST; otherwise -> FAULT.
  - If lock_s rises on the timeout cycle, lock wins.
- SETTLE:
  - lock_s=0 restarts the timer and stays in SETTLE; this is not counted as a failure.
  - After SETTLE_CYCLES consecutive lock_s=1 cycles -> RUN.
- RUN:
  - ready=1 and link_reset=0, both registered and asserted in the first RUN cycle.
  - lock_s=0 -> PLL_RST:
    - ready and link_reset respond in the next cycle.
    - retry_cnt increments.
    - The MAX_RETRIES check applies as in WAIT_LOCK.
- FAULT:
  - mgr_reset=1, link_reset=1, fault=1.
  - Left only by fault_clr=1 -> IDLE.
- enable=0 in any state except FAULT -> IDLE on the next edge. enable takes priority over lock events in the same cycle.
- fault_clr in any state other than FAULT is ignored.
- link_reset is 0 only in RUN.
- retry_cnt saturates at 255 and never wraps. The timer never wraps; it is cleared on every transition.
- Asynchronous reset mid-sequence returns everything to reset values immediately. Reset release proceeds from IDLE.

Optional Feature:
- Macro: JESD204_LOCK_DEGLITCH_EN.
- Defined:
  - In RUN, lock_s must be low for 4 consecutive cycles before loss of lock is declared.
  - Shorter dropouts are ignored and clear the filter counter.
  - WAIT_LOCK and SETTLE are unaffected.
- Undefined:
  - A single low cycle of lock_s in RUN triggers loss of lock.
  - No filter logic is present.

Decomposition:
- Shared package jesd204_clk_pkg holds:
  - the state encoding constants (3-bit);
  - DEGLITCH_LEN=4;
  - retry_cnt width 8.
- One natural sub-module is jesd204_sync_2ff: a parameterised-width 2-flop synchronizer with async reset, reused for other async status inputs.

Test Plan:
- Nominal bring-up:
  - Stimulus: RST_CYCLES=16, enable=1 at t0, mgr_locked rising 50 cycles after mgr_reset falls, held high.
  - Response: mgr_reset high 16 cycles; ready=1 exactly 2+256 cycles after lock rises; retry_cnt=0.
- Timeout/fault:
  - Stimulus: LOCK_TIMEOUT=64, MAX_RETRIES=3, mgr_locked tied 0.
  - Response: four mgr_reset pulses; FAULT entered with retry_cnt=4 and fault=1; fault_clr -> IDLE.
- Settle restart:
  - Stimulus: lock drops for 1 cycle at settle cycle 100.
  - Response: ready delayed to 256 cycles after re-assertion; no retry_cnt change.
- Loss of lock in RUN:
  - Stimulus: lock low for 10 cycles while ready=1.
  - Response: ready/link_reset change within 3 cycles of the mgr_locked fall (or 6 cycles with deglitch); new mgr_reset pulse; retry_cnt=1.
- Deglitch (macro defined):
  - Stimulus: 3-cycle low glitch in RUN.
  - Response: ready stays 1. With the macro undefined, the same glitch causes a relock.
- Enable/reset interrupts:
  - Stimulus: enable=0 in WAIT_LOCK, or async reset asserted mid-SETTLE.
  - Response: IDLE next edge with mgr_reset=1, link_reset=1, retry_cnt=0.
